// File: rtl/prores_dc_pkg.sv
// Shared constants and types for the DC VLC stage: codebooks, FSM states and DC saturation limits.
package prores_dc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        DELTA = 2'd2,
        DRAIN = 2'd3
    } dc_state_e;

    localparam logic [7:0] FIRST_DC_CB = 8'hB8;

    // Indexed by the adaptive codebook index; entry 0 is the least significant byte.
    localparam logic [3:0][7:0] DC_CB = {8'h70, 8'h4D, 8'h28, 8'h04};

    localparam int DC_MAX = 2047;
    localparam int DC_MIN = -2048;

endpackage

// File: rtl/dc_vlc_codeword.sv
// Combinational Rice/exp-Golomb hybrid codeword builder driven by a packed codebook byte.
module dc_vlc_codeword (
    input  logic [7:0]  cb,
    input  logic [31:0] value,
    output logic [31:0] bits,
    output logic [5:0]  len
);

    function automatic logic [31:0] msb_pos(input logic [31:0] x);
        msb_pos = '0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) msb_pos = 32'(i);
        end
    endfunction

    logic [31:0] sw, rice, ex, sv, v2, e;

    // Leading zeros are implicit in the length, so bits only carries the significant tail.
    always_comb begin
        sw   = 32'(cb[1:0]) + 32'd1;
        rice = 32'(cb[7:5]);
        ex   = 32'(cb[4:2]);
        sv   = sw << rice;
        v2   = '0;
        e    = '0;
        if (value >= sv) begin
            v2   = value - sv + (32'd1 << ex);
            e    = msb_pos(v2);
            bits = v2;
            len  = 6'(e - ex + sw + e + 32'd1);
        end else begin
            bits = (32'd1 << rice) | (value & ((32'd1 << rice) - 32'd1));
            len  = 6'((value >> rice) + 32'd1 + rice);
        end
    end

endmodule

// File: rtl/dc_vlc_encoder.sv
// DC coefficient VLC encoder: first DC coded directly, the rest as sign-folded adaptive deltas.
// Optional bit counter output dc_bits is enabled by defining DC_VLC_BITCOUNT_EN.
module dc_vlc_encoder
    import prores_dc_pkg::*;
#(
    parameter int MAX_BLOCK_NUM = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] block_num,
    input  logic [31:0] dc_in,
    input  logic        dc_valid,
    output logic        dc_ready,
    output logic [31:0] code_bits,
    output logic [5:0]  code_len,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        busy,
`ifdef DC_VLC_BITCOUNT_EN
    output logic [15:0] dc_bits,
`endif
    output logic        done
);

    function automatic logic signed [11:0] sat_dc(input logic signed [31:0] x);
        if (x > DC_MAX) return 12'(DC_MAX);
        if (x < DC_MIN) return 12'(DC_MIN);
        return x[11:0];
    endfunction

    function automatic logic [31:0] clamp_blk(input logic [31:0] n);
        if (n == 32'd0) return 32'd1;
        if (n > 32'(MAX_BLOCK_NUM)) return 32'(MAX_BLOCK_NUM);
        return n;
    endfunction

    function automatic logic [31:0] zigzag(input logic signed [31:0] x);
        return (x <<< 1) ^ (x >>> 31);
    endfunction

    dc_state_e          state;
    logic [31:0]        blk_total, blk_cnt;
    logic signed [11:0] prev_dc;
    logic               sign_q;
    logic [1:0]         cb_idx;
    logic [31:0]        bits_p1;
    logic [5:0]         len_p1;
    logic               vld_p1;
    logic               busy_q, done_q;

    // Stage p0: saturate, form the folded value and select the codebook.
    logic signed [11:0] dc_sat_p0;
    logic signed [31:0] dc_ext_p0, prev_ext_p0, delta_p0, mag_p0;
    logic [31:0]        code_p0, half_p0, cw_bits_p0;
    logic [7:0]         cb_p0;
    logic [5:0]         cw_len_p0;
    logic [1:0]         cb_next_p0;
    logic               accept, out_hs;

    always_comb begin
        dc_sat_p0   = sat_dc(signed'(dc_in));
        dc_ext_p0   = {{20{dc_sat_p0[11]}}, dc_sat_p0};
        prev_ext_p0 = {{20{prev_dc[11]}}, prev_dc};
        delta_p0    = dc_ext_p0 - prev_ext_p0;
        mag_p0      = sign_q ? -delta_p0 : delta_p0;
        if (state == FIRST) begin
            code_p0 = zigzag(dc_ext_p0);
            cb_p0   = FIRST_DC_CB;
        end else begin
            code_p0 = zigzag(mag_p0);
            cb_p0   = DC_CB[cb_idx];
        end
        half_p0    = (code_p0 + {31'b0, code_p0[0]}) >> 1;
        cb_next_p0 = (half_p0 > 32'd3) ? 2'd3 : half_p0[1:0];
    end

    dc_vlc_codeword u_codeword (
        .cb    (cb_p0),
        .value (code_p0),
        .bits  (cw_bits_p0),
        .len   (cw_len_p0)
    );

    assign dc_ready   = ((state == FIRST) || (state == DELTA)) && (!vld_p1 || code_ready);
    assign accept     = dc_valid && dc_ready;
    assign out_hs     = vld_p1 && code_ready;
    assign code_bits  = bits_p1;
    assign code_len   = len_p1;
    assign code_valid = vld_p1;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef DC_VLC_BITCOUNT_EN
    logic [15:0] bitcnt;
    assign dc_bits = bitcnt;
`endif

    // Stage p1: registered codeword and slice control.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            blk_total <= '0;
            blk_cnt   <= '0;
            prev_dc   <= '0;
            sign_q    <= 1'b0;
            cb_idx    <= '0;
            bits_p1   <= '0;
            len_p1    <= '0;
            vld_p1    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef DC_VLC_BITCOUNT_EN
            bitcnt    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                bits_p1 <= cw_bits_p0;
                len_p1  <= cw_len_p0;
                vld_p1  <= 1'b1;
            end else if (out_hs) begin
                vld_p1 <= 1'b0;
            end
`ifdef DC_VLC_BITCOUNT_EN
            if (state == IDLE && start) bitcnt <= '0;
            else if (out_hs) bitcnt <= bitcnt + 16'(len_p1);
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        blk_total <= clamp_blk(block_num);
                        blk_cnt   <= '0;
                        busy_q    <= 1'b1;
                        state     <= FIRST;
                    end
                end
                FIRST: begin
                    if (accept) begin
                        prev_dc <= dc_sat_p0;
                        sign_q  <= 1'b0;
                        cb_idx  <= 2'd3;
                        blk_cnt <= 32'd1;
                        state   <= (blk_total == 32'd1) ? DRAIN : DELTA;
                    end
                end
                DELTA: begin
                    if (accept) begin
                        prev_dc <= dc_sat_p0;
                        sign_q  <= delta_p0[31];
                        cb_idx  <= cb_next_p0;
                        blk_cnt <= blk_cnt + 32'd1;
                        if (blk_cnt + 32'd1 == blk_total) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!vld_p1 || out_hs) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dc_vlc_encoder.sv
// Randomized self-checking bench for dc_vlc_encoder against a behavioural codeword model.
module tb_dc_vlc_encoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] block_num = '0;
    logic [31:0] dc_in = '0;
    logic        dc_valid = 1'b0;
    logic        dc_ready;
    logic [31:0] code_bits;
    logic [5:0]  code_len;
    logic        code_valid;
    logic        code_ready = 1'b0;
    logic        busy;
    logic        done;
`ifdef DC_VLC_BITCOUNT_EN
    logic [15:0] dc_bits;
`endif

    int vectors = 0;
    int miscompares = 0;
    int exp_bits[$];
    int exp_len[$];

    always #5 clock = ~clock;

    dc_vlc_encoder #(.MAX_BLOCK_NUM(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .block_num  (block_num),
        .dc_in      (dc_in),
        .dc_valid   (dc_valid),
        .dc_ready   (dc_ready),
        .code_bits  (code_bits),
        .code_len   (code_len),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .busy       (busy),
`ifdef DC_VLC_BITCOUNT_EN
        .dc_bits    (dc_bits),
`endif
        .done       (done)
    );

    // Codeword for one value, straight from the codebook field definitions.
    task automatic model_cw(input int cb, input int v);
        int sw, rice, ex, sv, v2, e;
        sw   = (cb & 3) + 1;
        rice = (cb >> 5) & 7;
        ex   = (cb >> 2) & 7;
        sv   = sw * (1 << rice);
        if (v >= sv) begin
            v2 = v - sv + (1 << ex);
            e  = $clog2(v2 + 1) - 1;
            exp_bits.push_back(v2);
            exp_len.push_back((e - ex + sw) + (e + 1));
        end else begin
            exp_bits.push_back((1 << rice) + (v % (1 << rice)));
            exp_len.push_back(v / (1 << rice) + 1 + rice);
        end
    endtask

    task automatic build_model(input int n, input int dcs[$]);
        int cbtab[4] = '{'h04, 'h28, 'h4D, 'h70};
        int prev, sgn, cbi, x, d, m, v;
        exp_bits.delete();
        exp_len.delete();
        prev = 0; sgn = 0; cbi = 0;
        for (int i = 0; i < n; i++) begin
            x = dcs[i] > 2047 ? 2047 : (dcs[i] < -2048 ? -2048 : dcs[i]);
            if (i == 0) begin
                v = (x >= 0) ? 2 * x : -2 * x - 1;
                model_cw('hB8, v);
                sgn = 0; cbi = 3;
            end else begin
                d = x - prev;
                m = sgn ? -d : d;
                v = (m >= 0) ? 2 * m : -2 * m - 1;
                model_cw(cbtab[cbi], v);
                cbi = ((v + (v % 2)) / 2 > 3) ? 3 : (v + (v % 2)) / 2;
                sgn = (d < 0) ? 1 : 0;
            end
            prev = x;
        end
    endtask

    task automatic run_slice(input int bn, input int dcs[$], input int rdy_pct, input int vld_pct,
                             input bit stall, input bit use_model, output int done_cyc);
        int n, in_cnt, out_cnt, cyc, last_hs, stall_left, sum;
        bit held, fin, exp_rdy;
        logic [31:0] hb;
        logic [5:0] hl;
        n = (bn < 1) ? 1 : ((bn > 32) ? 32 : bn);
        in_cnt = 0; out_cnt = 0; cyc = 0; last_hs = -10; sum = 0;
        stall_left = stall ? 3 : 0;
        held = 0; fin = 0; hb = '0; hl = '0; done_cyc = -1;
        if (use_model) build_model(n, dcs);
        @(negedge clock);
        start = 1'b1; block_num = 32'(bn);
        @(negedge clock);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        while (!fin && cyc < 3000) begin
            if (stall_left > 0 && out_cnt >= 1 && code_valid) begin
                code_ready = 1'b0;
                stall_left--;
            end else begin
                code_ready = ($urandom % 100) < rdy_pct;
            end
            dc_valid   = (in_cnt < dcs.size()) && (($urandom % 100) < vld_pct);
            dc_in      = (in_cnt < dcs.size()) ? 32'(dcs[in_cnt]) : $urandom;
            start      = (out_cnt < n) && ($urandom % 8 == 0);
            block_num  = $urandom;
            #1;
            if (done) begin
                fin = 1;
                done_cyc = cyc;
                vectors++;
                if (out_cnt != n || last_hs != cyc - 1) begin
                    miscompares++;
                    $display("FAIL done_timing: outputs %0d last_hs %0d cyc %0d want outputs %0d last_hs %0d",
                             out_cnt, last_hs, cyc, n, cyc - 1);
                end
`ifdef DC_VLC_BITCOUNT_EN
                vectors++;
                if (dc_bits !== 16'(sum)) begin
                    miscompares++;
                    $display("FAIL dc_bits: got %0d want %0d", dc_bits, sum);
                end
`endif
            end else begin
                exp_rdy = (in_cnt < n) && (!code_valid || code_ready);
                vectors++;
                if (dc_ready !== exp_rdy) begin
                    miscompares++;
                    $display("FAIL dc_ready: got %b want %b (cyc %0d)", dc_ready, exp_rdy, cyc);
                end
                if (held) begin
                    vectors++;
                    if (code_valid !== 1'b1 || code_bits !== hb || code_len !== hl) begin
                        miscompares++;
                        $display("FAIL hold_stable: got v%b %h/%0d want v1 %h/%0d",
                                 code_valid, code_bits, code_len, hb, hl);
                    end
                end
                if (code_valid && code_ready) begin
                    vectors++;
                    if (out_cnt >= n) begin
                        miscompares++;
                        $display("FAIL extra_codeword: got %h/%0d want none", code_bits, code_len);
                    end else if (code_bits !== 32'(exp_bits[out_cnt]) || code_len !== 6'(exp_len[out_cnt])) begin
                        miscompares++;
                        $display("FAIL codeword[%0d]: got %h/%0d want %h/%0d", out_cnt,
                                 code_bits, code_len, exp_bits[out_cnt], exp_len[out_cnt]);
                    end
                    out_cnt++;
                    last_hs = cyc;
                    sum += int'(code_len);
                end
                held = code_valid && !code_ready;
                hb = code_bits;
                hl = code_len;
                if (dc_valid && dc_ready) in_cnt++;
                @(negedge clock);
                cyc++;
            end
        end
        start = 1'b0; dc_valid = 1'b0; block_num = '0;
        if (!fin) begin
            vectors++;
            miscompares++;
            $display("FAIL slice_timeout: got no done in %0d cycles want done", cyc);
        end
        @(negedge clock);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || code_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done: got done %b busy %b valid %b want 0 0 0", done, busy, code_valid);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        vectors++;
        if (code_bits !== '0 || code_len !== '0 || code_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || dc_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got bits %h len %0d valid %b busy %b done %b rdy %b want all 0",
                     tag, code_bits, code_len, code_valid, busy, done, dc_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_idle_outputs("reset_state");
        reset_n = 1'b1;
    endtask

    task automatic test_spec_vectors();
        int dcs[$];
        int dcyc;
        dcs = '{0};
        exp_bits = '{'h20};
        exp_len = '{6};
        run_slice(1, dcs, 100, 100, 0, 0, dcyc);
        dcs = '{1, 1, 3, 2};
        exp_bits = '{'h22, 'h08, 'h05, 'h05};
        exp_len = '{6, 4, 5, 3};
        run_slice(4, dcs, 100, 100, 0, 0, dcyc);
    endtask

    task automatic test_saturation();
        int dcs[$];
        int dcyc;
        dcs = '{5000};
        run_slice(1, dcs, 100, 100, 0, 1, dcyc);
        dcs = '{-5000, 5000, -70000};
        run_slice(3, dcs, 70, 80, 0, 1, dcyc);
    endtask

    task automatic test_backpressure();
        int dcs[$];
        int dcyc;
        dcs.delete();
        for (int i = 0; i < 8; i++) dcs.push_back(int'($urandom_range(0, 800)) - 400);
        run_slice(8, dcs, 100, 100, 1, 1, dcyc);
    endtask

    task automatic test_back_to_back();
        int dcs[$];
        int dcyc;
        dcs.delete();
        for (int i = 0; i < 10; i++) dcs.push_back(int'($urandom_range(0, 4000)) - 2000);
        run_slice(10, dcs, 100, 100, 0, 1, dcyc);
        vectors++;
        if (dcyc != 11) begin
            miscompares++;
            $display("FAIL throughput: got done at cycle %0d want 11", dcyc);
        end
    endtask

    task automatic test_clamp();
        int dcs[$];
        int dcyc;
        dcs.delete();
        for (int i = 0; i < 40; i++) dcs.push_back(int'($urandom_range(0, 300)) - 150);
        run_slice(0, dcs, 90, 90, 0, 1, dcyc);
        run_slice(100, dcs, 90, 90, 0, 1, dcyc);
    endtask

    task automatic test_random();
        int dcs[$];
        int dcyc, bn;
        for (int s = 0; s < 12; s++) begin
            bn = int'($urandom_range(1, 32));
            dcs.delete();
            for (int i = 0; i < bn; i++) begin
                if (s % 3 == 0) dcs.push_back(int'($urandom_range(0, 8000)) - 4000);
                else dcs.push_back(int'($urandom_range(0, 60)) - 30);
            end
            run_slice(bn, dcs, 60, 70, s % 2 == 1, 1, dcyc);
        end
    endtask

    task automatic test_reset_mid();
        int dcs[$];
        int dcyc;
        @(negedge clock);
        start = 1'b1; block_num = 32'd8;
        @(negedge clock);
        start = 1'b0;
        code_ready = 1'b0;
        dc_valid = 1'b1;
        dc_in = 32'd100;
        repeat (3) @(negedge clock);
        #1;
        vectors++;
        if (code_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: got valid %b busy %b want 1 1", code_valid, busy);
        end
        reset_n = 1'b0;
        dc_valid = 1'b0;
        @(negedge clock);
        #1;
        check_idle_outputs("mid_reset");
        reset_n = 1'b1;
        dcs = '{1};
        exp_bits = '{'h22};
        exp_len = '{6};
        run_slice(1, dcs, 100, 100, 0, 0, dcyc);
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_clamp();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dc_vlc_encoder.md
DC_VLC_ENCODER -- requirements
Module: dc_vlc_encoder

Interface
REQ-001 Parameter: MAX_BLOCK_NUM, 32, upper bound on blocks per slice.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock.
REQ-004 Port: start  input  1  one-cycle pulse; begins a slice, latches block_num.
REQ-005 Port: block_num  input  32  DC values in the slice, legal range 1..MAX_BLOCK_NUM.
REQ-006 Port: dc_in  input  32  signed quantized DC from the mem_to_dc_vlc stage.
REQ-007 Port: dc_valid / dc_ready  input / output  1 / 1  valid-ready handshake for dc_in.
REQ-008 Port: code_bits  output  32  right-aligned codeword, MSB first on the wire.
REQ-009 Port: code_len  output  6  codeword length in bits, 1..31.
REQ-010 Port: code_valid / code_ready  output / input  1 / 1  valid-ready handshake for code_bits/code_len.
REQ-011 Port: busy  output  1  high from the cycle after start until done.
REQ-012 Port: done  output  1  one-cycle pulse in the cycle after the last codeword is accepted.

Function
REQ-013 States: IDLE, FIRST, DELTA, DRAIN. IDLE->FIRST on start. FIRST->DELTA on first dc accept. DELTA->DRAIN on accept of DC number block_num. DRAIN->IDLE when the output register empties; done asserts then.
REQ-014 If block_num is 1, FIRST goes directly to DRAIN.
REQ-015 block_num of 0, or above MAX_BLOCK_NUM, is clamped to 1 and MAX_BLOCK_NUM respectively.
REQ-016 dc_ready = (state is FIRST or DELTA) and (!code_valid or code_ready); handshake completes when dc_valid and dc_ready are both high.
REQ-017 Each accepted dc_in is saturated to the signed range -2048..2047 before use.
REQ-018 FIRST: code = (dc*2) XOR (dc>>>31), coded with codebook FIRST_DC_CB = 0xB8; prev_dc = dc, sign = 0, cb_idx = 3.
REQ-019 DELTA: d = dc - prev_dc, new_sign = d>>>31, d' = (d XOR sign) - sign, code = (d'*2) XOR (d'>>>31).
REQ-020 DELTA codebook: DC_CB[cb_idx] with DC_CB = {0x04, 0x28, 0x4D, 0x70}.
REQ-021 After each DELTA: cb_idx = min((code + code[0]) >> 1, 3); sign = new_sign; prev_dc = dc.
REQ-022 Codeword for codebook byte cb and value v:
- sw = cb[1:0]+1, rice = cb[7:5], exp = cb[4:2], sv = sw << rice.
- If v >= sv: v2 = v - sv + (1<<exp), e = floor(log2 v2); output (e-exp+sw) zeros, then v2 in e+1 bits.
- Else: output (v>>rice) zeros, a single 1, then v[rice-1:0].
REQ-023 The codeword is registered: code_valid rises the cycle after dc acceptance, and code_bits/code_len hold stable while code_valid is high and code_ready is low.
REQ-024 Acceptance and output in the same cycle sustain one codeword per cycle with no bubble.
REQ-025 A start pulse outside IDLE is ignored.

Reset
REQ-026 On reset_n low at a clock edge, the block returns to IDLE and clears code_bits, code_len, code_valid, busy, done, prev_dc, sign and cb_idx to 0; any codeword held at that point is discarded.

Configuration
REQ-027 With DC_VLC_BITCOUNT_EN defined, the block adds output dc_bits [15:0]:
- cleared on start;
- increased by code_len on each output handshake;
- held after done.
Without DC_VLC_BITCOUNT_EN, the port and its counter are absent.

Structure
REQ-028 Package prores_dc_pkg holds FIRST_DC_CB, DC_CB, the state enum and the saturation limits.
REQ-029 Sub-module dc_vlc_codeword is purely combinational: input is a codebook byte and value, outputs are bits and length. It is reusable by the AC stage.

Verification
REQ-030 block_num=1, dc_in=0 -> one codeword, code_bits=0x20, len 6; done one cycle after accept.
REQ-031 block_num=4, dc_in 1,1,3,2 -> codewords (0x22,6), (0x08,4), (0x05,5), (0x05,3); final cb_idx=1.
REQ-032 dc_in=5000 with block_num=1 -> encoded as 2047 (code 4094, cb 0xB8).
REQ-033 code_ready held low 3 cycles mid-slice -> dc_ready low, outputs stable, no codeword lost or duplicated.
REQ-034 reset_n low during DELTA with code_valid high -> next cycle IDLE, all outputs 0; new start encodes first DC with 0xB8.
REQ-035 With DC_VLC_BITCOUNT_EN defined, the REQ-031 stimulus gives dc_bits = 18.
